hard_mem_1rw_arbiter: RTL and testbench
=======================================

Name: hard_mem_1rw_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port 1024x46 hard SRAM wrapper (hard_mem_1rw_d1024_w46_wrapper).
- Grants at most one access per cycle, round-robin.
- Drives the wrapper's active-low chip-select/write-enable.
- Returns read data one cycle after grant.
- Optional post-reset zero-fill of the whole array.
- Sits between the tile's compute-side and network-side memory clients and the SRAM macro.

Parameters:
ADDR_WIDTH, 10, address bits; depth = 1<<ADDR_WIDTH
DATA_WIDTH, 46, data word width
NUM_WMASKS, 1, write-mask bits passed through to the macro

Ports:
clk_i  input  1  clock; all state updates on rising edge
reset_i  input  1  synchronous, active-high reset
r0_v_i  input  1  requester 0 request valid
r0_w_i  input  1  requester 0 write (1) / read (0)
r0_addr_i  input  ADDR_WIDTH  requester 0 address
r0_data_i  input  DATA_WIDTH  requester 0 write data
r0_mask_i  input  NUM_WMASKS  requester 0 write mask
r0_yumi_o  output  1  requester 0 granted this cycle
r0_v_o  output  1  requester 0 read data valid
r1_*  (same seven signals as r0_*)  requester 1
data_o  output  DATA_WIDTH  read data, shared by both requesters
mem_v_o  output  1  to wrapper v_i; ACTIVE-LOW chip select
mem_w_o  output  1  to wrapper w_i; ACTIVE-LOW write enable
mem_addr_o  output  ADDR_WIDTH  to wrapper addr_i
mem_data_o  output  DATA_WIDTH  to wrapper data_i
mem_mask_o  output  NUM_WMASKS  to wrapper write_mask_i
mem_data_i  input  DATA_WIDTH  from wrapper data_o
init_done_o  output  1  array ready for requester traffic

Behaviour:
- Clock and reset: single clock clk_i. reset_i is synchronous and active-high.
- Reset values, in and immediately after any reset cycle:
  - mem_v_o=1, mem_w_o=1 (macro idle)
  - r0_yumi_o=r1_yumi_o=0, r0_v_o=r1_v_o=0
  - data_o=0
  - last_grant=1, so requester 0 wins the first contention
  - init_done_o=0
- States: INIT, RUN. Reset enters INIT.
  - Without the optional feature, INIT lasts exactly one cycle, then RUN.
- Arbitration in RUN (combinational, same cycle):
  - Only r0_v_i asserted: grant 0.
  - Only r1_v_i asserted: grant 1.
  - Both asserted: grant the requester that is not last_grant.
  - last_grant updates only on a grant.
- yumi_o is asserted for the granted requester only; never asserted when v_i=0.
- Requests are not registered: a requester holds v/w/addr/data/mask until yumi.
- Memory drive in the grant cycle:
  - mem_v_o=0.
  - mem_w_o = ~w of the winner.
  - addr/data/mask are muxed from the winner.
- No-grant cycle: mem_v_o=1, mem_w_o=1, addr/data/mask are don't-care (hold previous value).
- Read latency: a granted read in cycle N produces rX_v_o=1 in cycle N+1 for exactly one cycle, with data_o=mem_data_i.
- data_o is registered and holds the last read value until the next read response. Writes do not change data_o.
- Writes produce no response; yumi is the completion.
- Back-to-back grants, alternating or repeated, are allowed every cycle. A read response in N+1 coexists with a new grant in N+1.
- Reset mid-operation: any pending N+1 read response is dropped (v_o=0) and arbitration state returns to reset values.
- No starvation: under continuous contention, grants strictly alternate 0,1,0,1.

Optional Feature:
Macro HARD_MEM_ARB_INIT_CLEAR_EN.
- Defined: INIT zero-fills the array.
  - Address counter runs 0..(1<<ADDR_WIDTH)-1.
  - One write per cycle: mem_v_o=0, mem_w_o=0, mem_data_o=0, mem_mask_o all ones.
  - Takes 1024 cycles at the default depth.
  - Both yumi_o held 0 throughout.
  - Enters RUN and sets init_done_o=1 the cycle after writing the last address.
  - Counter wrap-around terminates INIT; it does not restart it.
  - Reset during INIT restarts the fill at address 0.
- Undefined: no fill; init_done_o=1 from the second cycle after reset deasserts.

Test Plan:
1. Reset, then r0 write addr 0x3FF data 0x2A_BCDE_F012 mask 1; r0 read 0x3FF -> yumi same cycle; r0_v_o=1 next cycle with data_o=0x2ABCDEF012; mem_v_o=0 and mem_w_o=0 only on the write cycle.
2. r0_v_i and r1_v_i held high for 6 cycles after reset -> grants 0,1,0,1,0,1; never both yumi.
3. r1 read addr 5, then r0 read addr 6 in the next cycle -> r1_v_o in cycle 2, r0_v_o in cycle 3, each with the correct data, never both high together.
4. Assert reset_i in the cycle after a granted read -> r0_v_o=0, mem_v_o=1, data_o=0 next cycle; next contention grants r0 first.
5. With HARD_MEM_ARB_INIT_CLEAR_EN: hold r0_v_i high from reset -> no yumi for 1024 cycles; init_done_o rises at cycle 1025; reading addr 0x155 returns 0.
6. Without the macro: init_done_o=1 at cycle 2 after reset; reads of previously written data return it unchanged; writes leave data_o unchanged.

Source files
------------

// File: rtl/hard_mem_1rw_arbiter.sv
// Round-robin two-requester arbiter/sequencer for the 1024x46 single-port SRAM wrapper.
// Define HARD_MEM_ARB_INIT_CLEAR_EN to zero-fill the array after reset.
module hard_mem_1rw_arbiter #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 46,
   parameter int unsigned NUM_WMASKS = 1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  r0_v_i,
   input  logic                  r0_w_i,
   input  logic [ADDR_WIDTH-1:0] r0_addr_i,
   input  logic [DATA_WIDTH-1:0] r0_data_i,
   input  logic [NUM_WMASKS-1:0] r0_mask_i,
   output logic                  r0_yumi_o,
   output logic                  r0_v_o,
   input  logic                  r1_v_i,
   input  logic                  r1_w_i,
   input  logic [ADDR_WIDTH-1:0] r1_addr_i,
   input  logic [DATA_WIDTH-1:0] r1_data_i,
   input  logic [NUM_WMASKS-1:0] r1_mask_i,
   output logic                  r1_yumi_o,
   output logic                  r1_v_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  mem_v_o,
   output logic                  mem_w_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   output logic [NUM_WMASKS-1:0] mem_mask_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   output logic                  init_done_o
);

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e                state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic [1:0]            rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [NUM_WMASKS-1:0] mask_q;
   logic                  grant0, grant1, granted;
   logic                  win_w;
   logic [ADDR_WIDTH-1:0] win_addr;
   logic [DATA_WIDTH-1:0] win_data;
   logic [NUM_WMASKS-1:0] win_mask;

`ifdef HARD_MEM_ARB_INIT_CLEAR_EN
   logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
`endif

   // Arbitration; last_grant_q == 1 means requester 0 wins the next tie.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (!reset_i && state_q == StRun) begin
         if (r0_v_i && r1_v_i) begin
            grant0 = last_grant_q;
            grant1 = ~last_grant_q;
         end else begin
            grant0 = r0_v_i;
            grant1 = r1_v_i;
         end
      end
   end

   assign granted  = grant0 | grant1;
   assign win_w    = grant1 ? r1_w_i    : r0_w_i;
   assign win_addr = grant1 ? r1_addr_i : r0_addr_i;
   assign win_data = grant1 ? r1_data_i : r0_data_i;
   assign win_mask = grant1 ? r1_mask_i : r0_mask_i;

   always_comb begin
      mem_v_o      = 1'b1;
      mem_w_o      = 1'b1;
      mem_addr_o   = addr_q;
      mem_data_o   = wdata_q;
      mem_mask_o   = mask_q;
      state_d      = state_q;
      last_grant_d = last_grant_q;
`ifdef HARD_MEM_ARB_INIT_CLEAR_EN
      clr_cnt_d    = clr_cnt_q;
`endif
      unique case (state_q)
         StInit: begin
`ifdef HARD_MEM_ARB_INIT_CLEAR_EN
            if (!reset_i) begin
               mem_v_o    = 1'b0;
               mem_w_o    = 1'b0;
               mem_addr_o = clr_cnt_q;
               mem_data_o = '0;
               mem_mask_o = '1;
               clr_cnt_d  = clr_cnt_q + 1'b1;
               // Wrap of the counter ends the fill rather than restarting it.
               if (clr_cnt_q == '1) state_d = StRun;
            end
`else
            state_d = StRun;
`endif
         end
         StRun: begin
            if (granted) begin
               mem_v_o      = 1'b0;
               mem_w_o      = ~win_w;
               mem_addr_o   = win_addr;
               mem_data_o   = win_data;
               mem_mask_o   = win_mask;
               last_grant_d = grant1;
            end
         end
         default: state_d = StInit;
      endcase
   end

   assign rvalid_d = {grant1 & ~r1_w_i, grant0 & ~r0_w_i};
   // The macro's read data is valid in the response cycle; capture it so it holds afterwards.
   assign data_d   = (|rvalid_q) ? mem_data_i : data_q;

   assign r0_yumi_o   = grant0;
   assign r1_yumi_o   = grant1;
   assign r0_v_o      = rvalid_q[0] & ~reset_i;
   assign r1_v_o      = rvalid_q[1] & ~reset_i;
   assign data_o      = reset_i ? '0 : data_d;
   assign init_done_o = (state_q == StRun) & ~reset_i;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q      <= StInit;
         last_grant_q <= 1'b1;
         rvalid_q     <= 2'b00;
         data_q       <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
         mask_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         rvalid_q     <= rvalid_d;
         data_q       <= data_d;
         addr_q       <= mem_addr_o;
         wdata_q      <= mem_data_o;
         mask_q       <= mem_mask_o;
      end
   end

`ifdef HARD_MEM_ARB_INIT_CLEAR_EN
   always_ff @(posedge clk_i) begin
      if (reset_i) clr_cnt_q <= '0;
      else         clr_cnt_q <= clr_cnt_d;
   end
`endif

endmodule

// File: tb/tb_hard_mem_1rw_arbiter.sv
// Directed bench for hard_mem_1rw_arbiter with a behavioural SRAM and a per-cycle scoreboard.
module tb_hard_mem_1rw_arbiter;

   localparam logic [45:0] INIT_PAT = 46'h15A5_A5A5_A5A5;
`ifdef HARD_MEM_ARB_INIT_CLEAR_EN
   localparam int INIT_CYCLES = 1024;
`else
   localparam int INIT_CYCLES = 1;
`endif

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        r0_v_i = 0, r0_w_i = 0, r1_v_i = 0, r1_w_i = 0;
   logic [9:0]  r0_addr_i = '0, r1_addr_i = '0;
   logic [45:0] r0_data_i = '0, r1_data_i = '0;
   logic [0:0]  r0_mask_i = '0, r1_mask_i = '0;
   logic        r0_yumi_o, r0_v_o, r1_yumi_o, r1_v_o;
   logic [45:0] data_o, mem_data_o, mem_data_i;
   logic        mem_v_o, mem_w_o, init_done_o;
   logic [9:0]  mem_addr_o;
   logic [0:0]  mem_mask_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hard_mem_1rw_arbiter dut (
      .clk_i(clk), .reset_i(reset_i),
      .r0_v_i(r0_v_i), .r0_w_i(r0_w_i), .r0_addr_i(r0_addr_i), .r0_data_i(r0_data_i),
      .r0_mask_i(r0_mask_i), .r0_yumi_o(r0_yumi_o), .r0_v_o(r0_v_o),
      .r1_v_i(r1_v_i), .r1_w_i(r1_w_i), .r1_addr_i(r1_addr_i), .r1_data_i(r1_data_i),
      .r1_mask_i(r1_mask_i), .r1_yumi_o(r1_yumi_o), .r1_v_o(r1_v_o),
      .data_o(data_o), .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_mask_o(mem_mask_o), .mem_data_i(mem_data_i),
      .init_done_o(init_done_o)
   );

   // Behavioural macro: active-low v/w, one-cycle registered read.
   logic [45:0] sram [1024];
   logic [45:0] sram_q = '0;
   initial for (int i = 0; i < 1024; i++) sram[i] = INIT_PAT;
   always @(posedge clk) begin
      if (!mem_v_o) begin
         if (!mem_w_o) begin
            if (mem_mask_o[0]) sram[mem_addr_o] <= mem_data_o;
         end else begin
            sram_q <= sram[mem_addr_o];
         end
      end
   end
   assign mem_data_i = sram_q;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference model state, advanced once per cycle at the negedge.
   logic [45:0] ref_mem [1024];
   logic [46:0] exp_q [$];
   int          rc = 0;
   logic        m_last = 1'b1;
   logic [45:0] m_data = '0;
   initial for (int i = 0; i < 1024; i++) ref_mem[i] = INIT_PAT;

   always @(negedge clk) begin
      logic        g0, g1, gw, gm;
      logic [9:0]  ga;
      logic [45:0] gd, edata;
      logic [46:0] e;
      logic [1:0]  ev;
      if (reset_i) begin
         chk("rst_yumi", {r1_yumi_o, r0_yumi_o}, 2'b00);
         chk("rst_rvalid", {r1_v_o, r0_v_o}, 2'b00);
         chk("rst_data", data_o, 0);
         chk("rst_mem", {mem_v_o, mem_w_o}, 2'b11);
         chk("rst_done", init_done_o, 0);
         rc = 0;
         m_last = 1'b1;
         m_data = '0;
         exp_q.delete();
      end else begin
         ev = 2'b00;
         edata = m_data;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            ev = e[46] ? 2'b10 : 2'b01;
            edata = e[45:0];
         end
         m_data = edata;
         chk("mon_rvalid", {r1_v_o, r0_v_o}, ev);
         chk("mon_data", data_o, edata);
         chk("mon_done", init_done_o, rc >= INIT_CYCLES);
         if (rc >= INIT_CYCLES) begin
            if (r0_v_i && r1_v_i) begin
               g0 = m_last;
               g1 = ~m_last;
            end else begin
               g0 = r0_v_i;
               g1 = r1_v_i;
            end
            chk("mon_grant", {r1_yumi_o, r0_yumi_o}, {g1, g0});
            if (g0 || g1) begin
               gw = g1 ? r1_w_i : r0_w_i;
               ga = g1 ? r1_addr_i : r0_addr_i;
               gd = g1 ? r1_data_i : r0_data_i;
               gm = g1 ? r1_mask_i[0] : r0_mask_i[0];
               chk("mon_memctl", {mem_v_o, mem_w_o}, {1'b0, ~gw});
               chk("mon_addr", mem_addr_o, ga);
               if (gw) begin
                  chk("mon_wdata", {mem_data_o, mem_mask_o}, {gd, gm});
                  if (gm) ref_mem[ga] = gd;
               end else begin
                  exp_q.push_back({g1, ref_mem[ga]});
               end
               m_last = g1;
            end else begin
               chk("mon_idle", {mem_v_o, mem_w_o}, 2'b11);
            end
         end else begin
            chk("init_yumi", {r1_yumi_o, r0_yumi_o}, 2'b00);
`ifdef HARD_MEM_ARB_INIT_CLEAR_EN
            chk("init_fill", {mem_v_o, mem_w_o, mem_addr_o, mem_data_o, mem_mask_o},
                {2'b00, rc[9:0], 46'h0, 1'b1});
            ref_mem[rc[9:0]] = '0;
`else
            chk("init_idle", {mem_v_o, mem_w_o}, 2'b11);
`endif
         end
         if (rc < 100000) rc++;
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      reset_i = 1'b1;
      @(posedge clk); #1;
      reset_i = 1'b0;
   endtask

   // Single request held until granted; returns one cycle after the grant with v dropped.
   task automatic do_req(input bit p, input bit w, input logic [9:0] a, input logic [45:0] d);
      bit got = 0;
      @(posedge clk); #1;
      if (p) begin
         r1_v_i = 1; r1_w_i = w; r1_addr_i = a; r1_data_i = d; r1_mask_i = 1'b1;
      end else begin
         r0_v_i = 1; r0_w_i = w; r0_addr_i = a; r0_data_i = d; r0_mask_i = 1'b1;
      end
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if ((p ? r1_yumi_o : r0_yumi_o) === 1'b1) begin
            got = 1;
            break;
         end
      end
      chk("req_grant_timeout", got, 1);
      @(posedge clk); #1;
      r0_v_i = 0;
      r1_v_i = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      bit got;
      do_reset();
`ifdef HARD_MEM_ARB_INIT_CLEAR_EN
      // Zero-fill: r0 held from the first post-reset cycle must wait 1024 cycles.
      r0_v_i = 1; r0_w_i = 0; r0_addr_i = 10'h155;
      cyc = 0;
      got = 0;
      for (int i = 1; i <= 1100; i++) begin
         @(negedge clk);
         if (r0_yumi_o === 1'b1) begin
            cyc = i;
            got = 1;
            break;
         end
      end
      chk("t5_first_yumi_cycle", cyc, 1025);
      chk("t5_done_at_yumi", init_done_o, 1);
      @(posedge clk); #1;
      r0_v_i = 0;
      @(negedge clk);
      chk("t5_rd_valid", r0_v_o, 1);
      chk("t5_rd_zero", data_o, 0);
`endif
      // Write then read at the top address.
      @(posedge clk); #1;
      r0_v_i = 1; r0_w_i = 1; r0_addr_i = 10'h3FF; r0_data_i = 46'h2ABCDEF012; r0_mask_i = 1;
      @(negedge clk);
      chk("t1_wr_yumi", r0_yumi_o, 1);
      chk("t1_wr_memctl", {mem_v_o, mem_w_o}, 2'b00);
      @(posedge clk); #1;
      r0_w_i = 0;
      @(negedge clk);
      chk("t1_rd_yumi", r0_yumi_o, 1);
      chk("t1_rd_memctl", {mem_v_o, mem_w_o}, 2'b01);
      @(posedge clk); #1;
      r0_v_i = 0;
      @(negedge clk);
      chk("t1_rd_valid", r0_v_o, 1);
      chk("t1_rd_data", data_o, 46'h2ABCDEF012);
      chk("t1_idle_memctl", {mem_v_o, mem_w_o}, 2'b11);

      // A write must leave data_o untouched.
      @(posedge clk); #1;
      r1_v_i = 1; r1_w_i = 1; r1_addr_i = 10'h007; r1_data_i = 46'h0000_1111_2222; r1_mask_i = 1;
      @(negedge clk);
      chk("t6_wr_yumi", r1_yumi_o, 1);
      @(posedge clk); #1;
      r1_v_i = 0;
      @(negedge clk);
      chk("t6_data_hold", data_o, 46'h2ABCDEF012);
      chk("t6_no_rvalid", {r1_v_o, r0_v_o}, 2'b00);
      do_req(1'b1, 1'b0, 10'h007, '0);
      @(negedge clk);
      chk("t6_rd_back", data_o, 46'h0000_1111_2222);

`ifndef HARD_MEM_ARB_INIT_CLEAR_EN
      // Continuous contention from reset: INIT cycle, then strict alternation.
      do_reset();
      r0_v_i = 1; r0_w_i = 0; r0_addr_i = 10'h3FF;
      r1_v_i = 1; r1_w_i = 0; r1_addr_i = 10'h007;
      @(negedge clk);
      chk("t2_init_nogrant", {r1_yumi_o, r0_yumi_o}, 2'b00);
      chk("t6_done_cycle1", init_done_o, 0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 0) chk("t6_done_cycle2", init_done_o, 1);
         chk("t2_alternate", {r1_yumi_o, r0_yumi_o}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      @(posedge clk); #1;
      r0_v_i = 0;
      r1_v_i = 0;
`endif

      // Back-to-back reads from different requesters.
      do_req(1'b0, 1'b1, 10'h005, 46'h05_0505_0505);
      do_req(1'b1, 1'b1, 10'h006, 46'h06_0606_0606);
      @(posedge clk); #1;
      r1_v_i = 1; r1_w_i = 0; r1_addr_i = 10'h005;
      @(negedge clk);
      chk("t3_r1_yumi", r1_yumi_o, 1);
      @(posedge clk); #1;
      r1_v_i = 0;
      r0_v_i = 1; r0_w_i = 0; r0_addr_i = 10'h006;
      @(negedge clk);
      chk("t3_r0_yumi", r0_yumi_o, 1);
      chk("t3_rsp1", {r1_v_o, r0_v_o}, 2'b10);
      chk("t3_rsp1_data", data_o, 46'h05_0505_0505);
      @(posedge clk); #1;
      r0_v_i = 0;
      @(negedge clk);
      chk("t3_rsp0", {r1_v_o, r0_v_o}, 2'b01);
      chk("t3_rsp0_data", data_o, 46'h06_0606_0606);

      // Reset in the response cycle drops the response and restores priority.
      @(posedge clk); #1;
      r0_v_i = 1; r0_w_i = 0; r0_addr_i = 10'h005;
      @(negedge clk);
      chk("t4_yumi", r0_yumi_o, 1);
      @(posedge clk); #1;
      r0_v_i = 0;
      reset_i = 1;
      @(negedge clk);
      chk("t4_drop", r0_v_o, 0);
      chk("t4_memv", mem_v_o, 1);
      chk("t4_data", data_o, 0);
      @(posedge clk); #1;
      reset_i = 0;
      r0_v_i = 1; r0_w_i = 0; r0_addr_i = 10'h006;
      r1_v_i = 1; r1_w_i = 0; r1_addr_i = 10'h005;
      @(negedge clk);
      chk("t4_after_rv", r0_v_o, 0);
      chk("t4_after_data", data_o, 0);
      got = 0;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         if ((r0_yumi_o | r1_yumi_o) === 1'b1) begin
            got = 1;
            break;
         end
      end
      chk("t4_grant_seen", got, 1);
      chk("t4_first_r0", {r1_yumi_o, r0_yumi_o}, 2'b01);
      @(posedge clk); #1;
      r0_v_i = 0;
      r1_v_i = 0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
